// File: rtl/simon_pkg.sv
// simon_pkg: shared widths, default round limit and FSM state encoding for the Simon Says controller
package simon_pkg;
  localparam int ROUND_W = 6;
  localparam int MAX_ROUND_DEF = 63;
  typedef enum logic [3:0] {
    READY1, READY2, READY3, READY4, SPEED_SEL, IS_NEXT_PULSE,
    PULSE_ON, PLAYER_TURN, DESELECT, WIN, LOSE
  } state_t;
endpackage

// File: rtl/fsm_sig.sv
// fsm_sig: bundle of simon_fsm outputs with a driver view and a consumer view
interface fsm_sig;
  import simon_pkg::*;
  logic [ROUND_W-1:0] current_round, pulse_idx, input_idx;
  logic [3:0] state;
  logic led_en, input_strobe, speed_up, game_win, game_lose;
  modport fsm (output current_round, pulse_idx, input_idx, state, led_en, input_strobe, speed_up, game_win, game_lose);
  modport view (input current_round, pulse_idx, input_idx, state, led_en, input_strobe, speed_up, game_win, game_lose);
endinterface

// File: rtl/simon_fsm.sv
// simon_fsm: Simon Says control FSM (start handshake, playback, input judging).
// SIMON_SPEED_SELECT_EN adds the SPEED_SEL window that latches a KEY2 speed-up request.
module simon_fsm
  import simon_pkg::*;
#(
  parameter int MAX_ROUND = MAX_ROUND_DEF,
  parameter int SPEED_WINDOW = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         launch_keys,
  input  logic               pulse,
  input  logic [3:0]         player_input,
  input  logic               result,
  output logic [ROUND_W-1:0] current_round,
  output logic [3:0]         state,
  output logic               led_en,
  output logic [ROUND_W-1:0] pulse_idx,
  output logic [ROUND_W-1:0] input_idx,
  output logic               input_strobe,
  output logic               speed_up,
  output logic               game_win,
  output logic               game_lose
);
  if (MAX_ROUND < 1 || MAX_ROUND >= 2 ** ROUND_W || SPEED_WINDOW < 1) begin : g_bad_cfg
    $error("simon_fsm: MAX_ROUND must be 1..63 and SPEED_WINDOW at least 1");
  end
  localparam logic [ROUND_W-1:0] MAX_R = ROUND_W'(MAX_ROUND);
  state_t state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d, pidx_q, pidx_d, iidx_q, iidx_d, iidx_inc;
  logic strobe_q, strobe_d, sel_done;
  fsm_sig sig();
`ifdef SIMON_SPEED_SELECT_EN
  localparam int CW = $clog2(SPEED_WINDOW + 1);
  localparam state_t START = SPEED_SEL;
  logic [CW-1:0] cnt_q, cnt_d;
  logic speed_q, speed_d;
  assign sel_done = cnt_q == CW'(SPEED_WINDOW - 1);
  always_comb begin
    cnt_d = state_q == SPEED_SEL ? cnt_q + 1'b1 : '0;
    speed_d = state_q == SPEED_SEL ? speed_q | launch_keys[1] :
              state_q inside {READY1, READY2, READY3, READY4} ? 1'b0 :
              state_q inside {WIN, LOSE} && launch_keys == 2'b11 ? 1'b0 : speed_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt_q <= '0;
      speed_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      speed_q <= speed_d;
    end
  assign sig.speed_up = speed_q;
`else
  localparam state_t START = IS_NEXT_PULSE;
  assign sel_done = 1'b0;
  assign sig.speed_up = 1'b0;
`endif
  assign iidx_inc = iidx_q + 1'b1;
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    pidx_d = pidx_q;
    iidx_d = iidx_q;
    strobe_d = 1'b0;
    case (state_q)
      READY1: state_d = launch_keys == 2'b01 ? READY2 : READY1;
      READY2: state_d = launch_keys == 2'b00 ? READY3 : READY2;
      READY3: state_d = launch_keys == 2'b11 ? READY4 : READY3;
      READY4:
        if (launch_keys == 2'b00) begin
          state_d = START;
          round_d = ROUND_W'(1);
          pidx_d = '0;
        end
      SPEED_SEL:
        if (sel_done) begin
          state_d = IS_NEXT_PULSE;
          pidx_d = '0;
        end
      IS_NEXT_PULSE:
        if (pulse) begin
          state_d = pidx_q < round_q ? PULSE_ON : PLAYER_TURN;
          iidx_d = pidx_q < round_q ? iidx_q : '0;
        end
      PULSE_ON:
        if (pulse) begin
          state_d = IS_NEXT_PULSE;
          pidx_d = pidx_q + 1'b1;
        end
      PLAYER_TURN:
        if ($onehot(player_input)) begin
          strobe_d = 1'b1;
          state_d = result ? DESELECT : LOSE;
        end
      DESELECT:
        if (player_input == 4'b0000) begin
          iidx_d = iidx_inc;
          if (iidx_inc < round_q) state_d = PLAYER_TURN;
          else if (round_q == MAX_R) state_d = WIN;
          else begin
            state_d = IS_NEXT_PULSE;
            round_d = round_q + 1'b1;
            pidx_d = '0;
          end
        end
      WIN, LOSE:
        if (launch_keys == 2'b11) begin
          state_d = READY1;
          round_d = '0;
          pidx_d = '0;
          iidx_d = '0;
        end
      default: state_d = READY1;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= READY1;
      round_q <= '0;
      pidx_q <= '0;
      iidx_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      pidx_q <= pidx_d;
      iidx_q <= iidx_d;
      strobe_q <= strobe_d;
    end
  assign sig.state = state_q;
  assign sig.current_round = round_q;
  assign sig.pulse_idx = pidx_q;
  assign sig.input_idx = iidx_q;
  assign sig.input_strobe = strobe_q;
  assign sig.led_en = state_q == PULSE_ON;
  assign sig.game_win = state_q == WIN;
  assign sig.game_lose = state_q == LOSE;
  assign state = sig.state;
  assign current_round = sig.current_round;
  assign pulse_idx = sig.pulse_idx;
  assign input_idx = sig.input_idx;
  assign input_strobe = sig.input_strobe;
  assign led_en = sig.led_en;
  assign speed_up = sig.speed_up;
  assign game_win = sig.game_win;
  assign game_lose = sig.game_lose;
endmodule

// File: tb/tb_simon_fsm.sv
// tb_simon_fsm: randomized game sessions checked against a round/index model of the Simon rules
module tb_simon_fsm;
  import simon_pkg::*;
  localparam int MR = 2;
  localparam int SW = 2;
`ifdef SIMON_SPEED_SELECT_EN
  localparam bit SPD_EN = 1'b1;
`else
  localparam bit SPD_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, pulse = 1'b0, result = 1'b0;
  logic [1:0] launch_keys = 2'b00;
  logic [3:0] player_input = 4'b0000;
  logic [5:0] current_round, pulse_idx, input_idx;
  logic [3:0] state;
  logic led_en, input_strobe, speed_up, game_win, game_lose;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  simon_fsm #(.MAX_ROUND(MR), .SPEED_WINDOW(SW)) dut (
    .clk(clk), .reset(reset), .launch_keys(launch_keys), .pulse(pulse),
    .player_input(player_input), .result(result), .current_round(current_round),
    .state(state), .led_en(led_en), .pulse_idx(pulse_idx), .input_idx(input_idx),
    .input_strobe(input_strobe), .speed_up(speed_up), .game_win(game_win), .game_lose(game_lose)
  );
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic test_reset();
    reset = 1'b0;
    cyc();
    checks++;
    if ({state, current_round, pulse_idx, input_idx, led_en, input_strobe, speed_up, game_win, game_lose} !== {4'(READY1), 23'b0}) begin
      errors++;
      $display("FAIL reset_values: state=%0d round=%0d pidx=%0d iidx=%0d led=%b strb=%b spd=%b win=%b lose=%b want all zero", state, current_round, pulse_idx, input_idx, led_en, input_strobe, speed_up, game_win, game_lose);
    end
    reset = 1'b1;
    launch_keys = 2'b11;
    repeat (3) cyc();
    checks++;
    if (state !== READY1) begin errors++; $display("FAIL ready1_keys11: state=%0d want %0d", state, READY1); end
    launch_keys = 2'b10;
    cyc();
    checks++;
    if (state !== READY1) begin errors++; $display("FAIL ready1_keys10: state=%0d want %0d", state, READY1); end
    launch_keys = 2'b00;
    cyc();
  endtask
  task automatic handshake(input bit req);
    logic [1:0] ks [6] = '{2'b01, 2'b01, 2'b00, 2'b11, 2'b11, 2'b00};
    state_t es [6] = '{READY2, READY2, READY3, READY4, READY4, SPD_EN ? SPEED_SEL : IS_NEXT_PULSE};
    int pick = $urandom_range(SW - 1);
    for (int i = 0; i < 6; i++) begin
      launch_keys = ks[i];
      cyc();
      checks++;
      if (state !== es[i]) begin errors++; $display("FAIL handshake_step%0d: state=%0d want %0d", i, state, es[i]); end
    end
    for (int i = 0; i < (SPD_EN ? SW : 0); i++) begin
      launch_keys = {req && i == pick, 1'($urandom)};
      cyc();
    end
    launch_keys = 2'b00;
    checks++;
    if ({state, current_round, pulse_idx, speed_up} !== {4'(IS_NEXT_PULSE), 6'd1, 6'd0, req & SPD_EN}) begin
      errors++;
      $display("FAIL handshake_done: state=%0d round=%0d pidx=%0d spd=%b want %0d 1 0 %b", state, current_round, pulse_idx, speed_up, IS_NEXT_PULSE, req & SPD_EN);
    end
  endtask
  task automatic play_round(input int r);
    for (int k = 0; k <= r; k++) begin
      pulse = 1'b0;
      repeat ($urandom_range(2)) begin
        player_input = 4'($urandom);
        cyc();
      end
      checks++;
      if ({state, pulse_idx, led_en} !== {4'(IS_NEXT_PULSE), 6'(k), 1'b0}) begin
        errors++;
        $display("FAIL play_off r%0d k%0d: state=%0d pidx=%0d led=%b want %0d %0d 0", r, k, state, pulse_idx, led_en, IS_NEXT_PULSE, k);
      end
      pulse = 1'b1;
      player_input = 4'($urandom);
      cyc();
      if (k == r) break;
      checks++;
      if ({state, led_en} !== {4'(PULSE_ON), 1'b1}) begin errors++; $display("FAIL play_on r%0d k%0d: state=%0d led=%b want %0d 1", r, k, state, led_en, PULSE_ON); end
      pulse = $urandom_range(1) == 1;
      if (!pulse) repeat ($urandom_range(2)) cyc();
      pulse = 1'b1;
      cyc();
    end
    pulse = 1'b0;
    player_input = 4'b0000;
    checks++;
    if ({state, input_idx, pulse_idx} !== {4'(PLAYER_TURN), 6'd0, 6'(r)}) begin
      errors++;
      $display("FAIL play_end r%0d: state=%0d iidx=%0d pidx=%0d want %0d 0 %0d", r, state, input_idx, pulse_idx, PLAYER_TURN, r);
    end
  endtask
  task automatic enter_input(input int r, input int idx, input bit ok);
    logic [3:0] v;
    bit nxt;
    repeat ($urandom_range(2)) begin
      do v = 4'($urandom); while ($countones(v) == 1);
      player_input = v;
      result = 1'($urandom);
      pulse = 1'($urandom);
      cyc();
      checks++;
      if ({state, input_strobe} !== {4'(PLAYER_TURN), 1'b0}) begin errors++; $display("FAIL invalid_sel %b: state=%0d strb=%b want %0d 0", v, state, input_strobe, PLAYER_TURN); end
    end
    player_input = 4'b0001 << $urandom_range(3);
    result = ok;
    cyc();
    checks++;
    if ({state, input_strobe, game_lose} !== {ok ? 4'(DESELECT) : 4'(LOSE), 1'b1, !ok}) begin
      errors++;
      $display("FAIL judge r%0d i%0d ok%b: state=%0d strb=%b lose=%b want %0d 1 %b", r, idx, ok, state, input_strobe, game_lose, ok ? DESELECT : LOSE, !ok);
    end
    if (!ok) return;
    repeat ($urandom_range(3, 1)) begin
      do player_input = 4'($urandom); while (player_input == 4'b0000);
      result = 1'($urandom);
      cyc();
      checks++;
      if ({state, input_strobe, input_idx} !== {4'(DESELECT), 1'b0, 6'(idx)}) begin
        errors++;
        $display("FAIL deselect_hold: state=%0d strb=%b iidx=%0d want %0d 0 %0d", state, input_strobe, input_idx, DESELECT, idx);
      end
    end
    player_input = 4'b0000;
    cyc();
    nxt = idx + 1 >= r && r != MR;
    checks++;
    if ({state, current_round, input_idx, pulse_idx, game_win} !==
        {idx + 1 < r ? 4'(PLAYER_TURN) : r == MR ? 4'(WIN) : 4'(IS_NEXT_PULSE), 6'(nxt ? r + 1 : r), 6'(idx + 1), nxt ? 6'd0 : 6'(r), idx + 1 >= r && r == MR}) begin
      errors++;
      $display("FAIL release r%0d i%0d: state=%0d round=%0d iidx=%0d pidx=%0d win=%b", r, idx, state, current_round, input_idx, pulse_idx, game_win);
    end
  endtask
  task automatic run_game(input bit req, input int fail_round, input int fail_idx);
    bit lost = 1'b0;
    logic [3:0] fin;
    handshake(req);
    for (int r = 1; r <= MR && !lost; r++) begin
      play_round(r);
      for (int i = 0; i < r && !lost; i++) begin
        lost = r == fail_round && i == fail_idx;
        enter_input(r, i, !lost);
      end
    end
    fin = lost ? 4'(LOSE) : 4'(WIN);
    repeat ($urandom_range(4, 1)) begin
      launch_keys = 2'($urandom_range(2));
      pulse = 1'($urandom);
      player_input = 4'($urandom);
      cyc();
    end
    checks++;
    if ({state, current_round, game_win, game_lose, speed_up} !== {fin, 6'(lost ? fail_round : MR), !lost, lost, req & SPD_EN}) begin
      errors++;
      $display("FAIL end_hold: state=%0d round=%0d win=%b lose=%b spd=%b want %0d %0d %b %b %b", state, current_round, game_win, game_lose, speed_up, fin, lost ? fail_round : MR, !lost, lost, req & SPD_EN);
    end
    launch_keys = 2'b11;
    player_input = 4'b0000;
    pulse = 1'b0;
    cyc();
    launch_keys = 2'b00;
    checks++;
    if ({state, current_round, pulse_idx, input_idx, speed_up, game_win, game_lose} !== {4'(READY1), 21'b0}) begin
      errors++;
      $display("FAIL restart: state=%0d round=%0d pidx=%0d iidx=%0d spd=%b win=%b lose=%b want ready1 zeros", state, current_round, pulse_idx, input_idx, speed_up, game_win, game_lose);
    end
    cyc();
  endtask
  task automatic test_win();
    run_game(1'b0, MR + 1, 0);
  endtask
  task automatic test_speed();
    run_game(1'b1, 1, 0);
  endtask
  task automatic test_random_games();
    repeat (8) begin
      int fr = $urandom_range(MR + 1, 1);
      run_game(1'($urandom), fr, $urandom_range(fr > MR ? 0 : fr - 1));
    end
  endtask
  task automatic test_async_reset();
    handshake(1'b1);
    pulse = 1'b1;
    cyc();
    pulse = 1'b0;
    checks++;
    if ({state, led_en} !== {4'(PULSE_ON), 1'b1}) begin errors++; $display("FAIL pre_reset: state=%0d led=%b want %0d 1", state, led_en, PULSE_ON); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({state, current_round, pulse_idx, input_idx, led_en, input_strobe, speed_up, game_win, game_lose} !== {4'(READY1), 23'b0}) begin
      errors++;
      $display("FAIL async_reset: state=%0d round=%0d pidx=%0d led=%b spd=%b want all zero", state, current_round, pulse_idx, led_en, speed_up);
    end
    cyc();
    reset = 1'b1;
    cyc();
    checks++;
    if (state !== READY1) begin errors++; $display("FAIL post_reset: state=%0d want %0d", state, READY1); end
  endtask
  initial begin
    test_reset();
    test_win();
    test_speed();
    test_random_games();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
